booth_pp_accum: RTL

Sequential radix-4 modified-Booth partial-product generator and accumulator for the 8-bit unsigned multiplier datapath. It sits directly downstream of the 2-bit-per-cycle multiplier PISO and consumes one 3-bit overlapping Booth group per cycle: group 0 first, then groups 1 to 4. For each group it selects 0, ±M or ±2M of the captured multiplicand, shifts it by the group weight and accumulates. After five groups it presents the 16-bit unsigned product with a one-cycle `done` pulse.

---
 rtl/booth_pp_accum_pkg.sv | 33 +++
 rtl/booth_pp_enc.sv | 30 +++
 rtl/booth_pp_accum.sv | 124 ++++++++++++
 3 files changed

// File: rtl/booth_pp_accum_pkg.sv
// Shared definitions for the radix-4 Booth partial-product accumulator:
// FSM states, Booth selection codes and datapath widths.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } booth_acc_state_t;

  localparam int unsigned ACC_W = 18;
  localparam int unsigned PP_W  = 10;

  localparam logic [2:0] BOOTH_ZERO = 3'd0;
  localparam logic [2:0] BOOTH_P1   = 3'd1;
  localparam logic [2:0] BOOTH_P2   = 3'd2;
  localparam logic [2:0] BOOTH_M1   = 3'd3;
  localparam logic [2:0] BOOTH_M2   = 3'd4;

  // Map a {b[2i+1], b[2i], b[2i-1]} group to the multiple it selects.
  function automatic logic [2:0] booth_sel(input logic [2:0] grp);
    logic [2:0] sel;
    unique case (grp)
      3'b001, 3'b010: sel = BOOTH_P1;
      3'b011:         sel = BOOTH_P2;
      3'b100:         sel = BOOTH_M2;
      3'b101, 3'b110: sel = BOOTH_M1;
      default:        sel = BOOTH_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_pp_enc.sv
// Combinational Booth encoder: selects 0, +/-M or +/-2M of the captured
// multiplicand as a PP_W-bit two's-complement partial product.
module booth_pp_enc
  import booth_pkg::*;
#(
  parameter int unsigned MCAND_W = 8
) (
  input  logic [2:0]         booth_grp,
  input  logic [MCAND_W-1:0] m,
  output logic [PP_W-1:0]    pp
);

  logic [PP_W-1:0] m1;
  logic [PP_W-1:0] m2;

  assign m1 = {{(PP_W-MCAND_W){1'b0}}, m};
  assign m2 = {m1[PP_W-2:0], 1'b0};

  always_comb begin
    pp = '0;
    unique case (booth_sel(booth_grp))
      BOOTH_P1: pp = m1;
      BOOTH_P2: pp = m2;
      BOOTH_M1: pp = -m1;
      BOOTH_M2: pp = -m2;
      default:  pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_pp_accum.sv
// Sequential radix-4 Booth partial-product accumulator (one group per cycle).
// Optional range check / ovf port enabled by defining BOOTH_PP_ACCUM_OVF_EN.
module booth_pp_accum
  import booth_pkg::*;
#(
  parameter int unsigned MCAND_W = 8,
  parameter int unsigned NGRP    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MCAND_W-1:0] mcand,
  input  logic [2:0]         booth_grp,
  output logic               busy,
  output logic               done,
`ifdef BOOTH_PP_ACCUM_OVF_EN
  output logic [15:0]        product,
  output logic               ovf
`else
  output logic [15:0]        product
`endif
);

  localparam int unsigned CNT_W = $clog2(NGRP);

  booth_acc_state_t          state_q, state_d;
  logic [MCAND_W-1:0]        m_q, m_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [15:0]               product_q, product_d;

  logic [PP_W-1:0]           pp;
  logic signed [ACC_W-1:0]   pp_ext;
  logic signed [ACC_W-1:0]   term;
  logic signed [ACC_W-1:0]   acc_next;
  logic                      last_grp;

  booth_pp_enc #(
    .MCAND_W (MCAND_W)
  ) u_enc (
    .booth_grp (booth_grp),
    .m         (m_q),
    .pp        (pp)
  );

  // Group i carries weight 4^i, so the shift is 2*cnt.
  assign pp_ext   = {{(ACC_W-PP_W){pp[PP_W-1]}}, pp};
  assign term     = pp_ext <<< {cnt_q, 1'b0};
  assign acc_next = acc_q + term;
  assign last_grp = (cnt_q == CNT_W'(NGRP-1));

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = mcand;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = acc_next;
        cnt_d = cnt_q + 1'b1;
        if (last_grp) begin
          product_d = acc_next[15:0];
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == ACC);
  assign done    = (state_q == DONE);
  assign product = product_q;

`ifdef BOOTH_PP_ACCUM_OVF_EN
  logic ovf_q, ovf_d;

  // A negative or >16-bit final sum can only come from a corrupt group stream.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == IDLE && start) begin
      ovf_d = 1'b0;
    end else if (state_q == ACC && last_grp) begin
      ovf_d = acc_next[ACC_W-1] | acc_next[16];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule
